// File: rtl/turnstile_fare_ctrl.sv
// Fare-collecting turnstile controller.
// Coins build credit until FARE is reached. The gate then unlocks for one
// passage and relocks on a push or when the unlock timeout expires. Credit
// left over after a push carries forward to the next passage. A passage
// counter tracks completed passages. Every output is driven from a register.
// Optional build macro TURNSTILE_ALARM_EN adds a sticky o_alarm output. It
// is set by a push while the gate is locked.
module turnstile_fare_ctrl #(
  parameter int FARE     = 3,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 100,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_coin,
  input  logic                i_push,
  input  logic                i_clear_count,
  output logic                o_locked,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [CNT_W-1:0]    o_pass_count,
  output logic                o_refund,
  output logic                o_timeout
`ifdef TURNSTILE_ALARM_EN
  ,
  output logic                o_alarm
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] FARE_C     = CREDIT_W'(FARE);
  localparam logic [CREDIT_W-1:0] CRED_MAX   = '1;
  localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {LOCKED = 1'b0, UNLOCKED = 1'b1} state_t;

  state_t              r_state;
  logic                r_locked;
  logic [CREDIT_W-1:0] r_credit;
  logic [CNT_W-1:0]    r_pass_count;
  logic [TW-1:0]       r_timer;
  logic                r_refund;
  logic                r_timeout;

  logic                w_sat;
  logic [CREDIT_W-1:0] w_cinc;
  logic [CREDIT_W-1:0] w_cnext;
  logic                w_pass;

  // Credit arithmetic: the incremented value, and the saturating
  // credit-plus-coin value used while unlocked.
  always_comb begin
    w_cinc  = r_credit + {{(CREDIT_W-1){1'b0}}, 1'b1};
    w_sat   = i_coin && (r_credit == CRED_MAX);
    w_cnext = r_credit;
    if (i_coin && !w_sat) begin
      w_cnext = w_cinc;
    end
    w_pass  = (r_state == UNLOCKED) && i_push;
  end

  // Gate FSM together with its credit, timer and pulse registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= LOCKED;
      r_locked  <= 1'b1;
      r_credit  <= '0;
      r_timer   <= '0;
      r_refund  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_refund  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        LOCKED: begin
          // Credit stays below FARE here, so the increment cannot wrap.
          if (i_coin) begin
            if (w_cinc == FARE_C) begin
              r_state  <= UNLOCKED;
              r_locked <= 1'b0;
              r_credit <= '0;
              r_timer  <= '0;
            end else begin
              r_credit <= w_cinc;
            end
          end
        end
        UNLOCKED: begin
          r_refund <= w_sat;
          if (i_push) begin
            if (w_cnext >= FARE_C) begin
              r_credit <= w_cnext - FARE_C;
              r_timer  <= '0;
            end else begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_credit <= w_cnext;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_state   <= LOCKED;
            r_locked  <= 1'b1;
            r_credit  <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_timer  <= r_timer + TW'(1);
            r_credit <= w_cnext;
          end
        end
        default: begin
          r_state  <= LOCKED;
          r_locked <= 1'b1;
        end
      endcase
    end
  end

  // Passage counter: a clear takes priority over an increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pass_count <= '0;
    end else if (i_clear_count) begin
      r_pass_count <= '0;
    end else if (w_pass) begin
      r_pass_count <= r_pass_count + CNT_W'(1);
    end
  end

`ifdef TURNSTILE_ALARM_EN
  logic r_alarm;

  // Sticky alarm: set by a push while locked, cleared together with the counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_alarm <= 1'b0;
    end else if (i_clear_count) begin
      r_alarm <= 1'b0;
    end else if ((r_state == LOCKED) && i_push) begin
      r_alarm <= 1'b1;
    end
  end

  assign o_alarm = r_alarm;
`endif

  assign o_locked     = r_locked;
  assign o_credit     = r_credit;
  assign o_pass_count = r_pass_count;
  assign o_refund     = r_refund;
  assign o_timeout    = r_timeout;

endmodule
